// File: rtl/disp_regbus_bridge.sv
// ---------------------------------------------------------------------------
// disp_regbus_bridge
//
// Purpose:
//   AXI4-Lite slave that initiates the display IP's internal register bus.
//   AW, W and AR each land in a one-entry holding buffer. From IDLE a single
//   transaction at a time is issued to the register bus and answered with an
//   OKAY response. When both a write and a read are waiting, the class that
//   was not granted last wins.
//
// Parameters:
//   AXI_AWIDTH : AXI address width; only bits [15:0] reach the register bus
//   RD_LATENCY : cycles from the RDEN cycle to the cycle RDATA is valid (1..4)
//
// Ports:
//   ACLK, ARST_X            : clock (rising edge), async active-low reset
//   S_AXI_AW* / S_AXI_W*    : AXI4-Lite write address / write data channels
//   S_AXI_B*                : write response channel (BRESP fixed to OKAY)
//   S_AXI_AR* / S_AXI_R*    : read address / read data channels (RRESP OKAY)
//   WRADDR/BYTEEN/WREN/WDATA: register bus write side, WREN is a 1-cycle strobe
//   RDADDR/RDEN/RDATA       : register bus read side, RDEN is a 1-cycle strobe
// ---------------------------------------------------------------------------
module disp_regbus_bridge #(
  parameter int AXI_AWIDTH = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                  ACLK,
  input  logic                  ARST_X,
  input  logic [AXI_AWIDTH-1:0] S_AXI_AWADDR,
  input  logic                  S_AXI_AWVALID,
  output logic                  S_AXI_AWREADY,
  input  logic [31:0]           S_AXI_WDATA,
  input  logic [3:0]            S_AXI_WSTRB,
  input  logic                  S_AXI_WVALID,
  output logic                  S_AXI_WREADY,
  output logic [1:0]            S_AXI_BRESP,
  output logic                  S_AXI_BVALID,
  input  logic                  S_AXI_BREADY,
  input  logic [AXI_AWIDTH-1:0] S_AXI_ARADDR,
  input  logic                  S_AXI_ARVALID,
  output logic                  S_AXI_ARREADY,
  output logic [31:0]           S_AXI_RDATA,
  output logic [1:0]            S_AXI_RRESP,
  output logic                  S_AXI_RVALID,
  input  logic                  S_AXI_RREADY,
  output logic [15:0]           WRADDR,
  output logic [3:0]            BYTEEN,
  output logic                  WREN,
  output logic [31:0]           WDATA,
  output logic [15:0]           RDADDR,
  output logic                  RDEN,
  input  logic [31:0]           RDATA
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_BR,
    S_RD,
    S_RW,
    S_RR
  } state_t;

  // Wait-counter terminal value; the RW state lasts RD_LATENCY cycles.
  localparam logic [1:0] LAT_LAST = 2'(RD_LATENCY - 1);

  state_t      r_state;
  logic        r_live;
  logic        r_aw_full;
  logic [15:0] r_aw_addr;
  logic        r_w_full;
  logic [31:0] r_w_data;
  logic [3:0]  r_w_strb;
  logic        r_ar_full;
  logic [15:0] r_ar_addr;
  logic        r_last_wr;
  logic [1:0]  r_cnt;
  logic        r_wren;
  logic [15:0] r_wraddr;
  logic [3:0]  r_byteen;
  logic [31:0] r_wdata;
  logic        r_rden;
  logic [15:0] r_rdaddr;
  logic        r_bvalid;
  logic        r_rvalid;
  logic [31:0] r_rdata;

  logic w_aw_hs;
  logic w_w_hs;
  logic w_ar_hs;
  logic w_wr_pend;
  logic w_rd_pend;
  logic w_grant_wr;
  logic w_grant_rd;
  logic w_unused;

  // Upper address bits are not forwarded to the register bus.
  assign w_unused = &{1'b0, S_AXI_AWADDR[AXI_AWIDTH-1:16],
                      S_AXI_ARADDR[AXI_AWIDTH-1:16]};

  // READYs come purely from registered flags. r_live keeps them low while in
  // reset so every output reads 0 until the first edge after release.
  assign S_AXI_AWREADY = r_live & ~r_aw_full;
  assign S_AXI_WREADY  = r_live & ~r_w_full;
  assign S_AXI_ARREADY = r_live & ~r_ar_full;

  assign w_aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_w_hs  = S_AXI_WVALID  & S_AXI_WREADY;
  assign w_ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

  assign w_wr_pend = r_aw_full & r_w_full;
  assign w_rd_pend = r_ar_full;

  // Write wins unless a read is also pending and the last grant was a write.
  assign w_grant_wr = (r_state == S_IDLE) & w_wr_pend & (~w_rd_pend | ~r_last_wr);
  assign w_grant_rd = (r_state == S_IDLE) & w_rd_pend & ~w_grant_wr;

  always_ff @(posedge ACLK or negedge ARST_X) begin
    if (!ARST_X) begin
      r_state   <= S_IDLE;
      r_live    <= 1'b0;
      r_aw_full <= 1'b0;
      r_aw_addr <= '0;
      r_w_full  <= 1'b0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
      r_ar_full <= 1'b0;
      r_ar_addr <= '0;
      r_last_wr <= 1'b0;
      r_cnt     <= '0;
      r_wren    <= 1'b0;
      r_wraddr  <= '0;
      r_byteen  <= '0;
      r_wdata   <= '0;
      r_rden    <= 1'b0;
      r_rdaddr  <= '0;
      r_bvalid  <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_live <= 1'b1;

      // Holding buffers load independently; a full buffer blocks its READY,
      // so a load can never coincide with the grant that empties it.
      if (w_aw_hs) begin
        r_aw_full <= 1'b1;
        r_aw_addr <= S_AXI_AWADDR[15:0];
      end
      if (w_w_hs) begin
        r_w_full <= 1'b1;
        r_w_data <= S_AXI_WDATA;
        r_w_strb <= S_AXI_WSTRB;
      end
      if (w_ar_hs) begin
        r_ar_full <= 1'b1;
        r_ar_addr <= S_AXI_ARADDR[15:0];
      end

      // Strobes are single-cycle pulses by default.
      r_wren <= 1'b0;
      r_rden <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_grant_wr) begin
            r_state   <= S_WR;
            r_wren    <= 1'b1;
            r_wraddr  <= r_aw_addr;
            r_byteen  <= r_w_strb;
            r_wdata   <= r_w_data;
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
            r_last_wr <= 1'b1;
          end else if (w_grant_rd) begin
            r_state   <= S_RD;
            r_rden    <= 1'b1;
            r_rdaddr  <= r_ar_addr;
            r_ar_full <= 1'b0;
            r_last_wr <= 1'b0;
          end
        end
        S_WR: begin
          r_state  <= S_BR;
          r_bvalid <= 1'b1;
        end
        S_BR: begin
          if (S_AXI_BREADY) begin
            r_bvalid <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        S_RD: begin
          r_state <= S_RW;
          r_cnt   <= '0;
        end
        S_RW: begin
          // RDATA is valid in the last RW cycle; capture it at that edge.
          if (r_cnt == LAT_LAST) begin
            r_rdata  <= RDATA;
            r_rvalid <= 1'b1;
            r_state  <= S_RR;
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        S_RR: begin
          if (S_AXI_RREADY) begin
            r_rvalid <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign S_AXI_BRESP  = 2'b00;
  assign S_AXI_BVALID = r_bvalid;
  assign S_AXI_RRESP  = 2'b00;
  assign S_AXI_RVALID = r_rvalid;
  assign S_AXI_RDATA  = r_rdata;
  assign WRADDR       = r_wraddr;
  assign BYTEEN       = r_byteen;
  assign WREN         = r_wren;
  assign WDATA        = r_wdata;
  assign RDADDR       = r_rdaddr;
  assign RDEN         = r_rden;

endmodule

// File: tb/tb_disp_regbus_bridge.sv
// ---------------------------------------------------------------------------
// tb_disp_regbus_bridge
//
// Two bridges share one AXI stimulus: instance A with RD_LATENCY=1 and
// instance B with RD_LATENCY=3. Each has its own register-bus read model that
// drives the addressed word only in the cycle RD_LATENCY after RDEN and a
// poison value at every other time. Table-driven write and read vectors are
// followed by hand-written sequences for the multi-cycle corner cases.
// ---------------------------------------------------------------------------
module tb_disp_regbus_bridge;

  logic        clk = 1'b0;
  logic        arst_x = 1'b0;
  logic [31:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        bready = 1'b0;
  logic [31:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        rready = 1'b0;

  logic        a_awready, a_wready, a_bvalid, a_arready, a_rvalid, a_wren, a_rden;
  logic [1:0]  a_bresp, a_rresp;
  logic [31:0] a_rdata, a_wdata, a_rdata_in;
  logic [15:0] a_wraddr, a_rdaddr;
  logic [3:0]  a_byteen;

  logic        b_awready, b_wready, b_bvalid, b_arready, b_rvalid, b_wren, b_rden;
  logic [1:0]  b_bresp, b_rresp;
  logic [31:0] b_rdata, b_wdata, b_rdata_in;
  logic [15:0] b_wraddr, b_rdaddr;
  logic [3:0]  b_byteen;

  int n_pass  = 0;
  int n_total = 0;
  logic overlap = 1'b0;

  always #5 clk = ~clk;

  disp_regbus_bridge #(.AXI_AWIDTH(32), .RD_LATENCY(1)) dut_a (
    .ACLK(clk), .ARST_X(arst_x),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(a_awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(a_wready),
    .S_AXI_BRESP(a_bresp), .S_AXI_BVALID(a_bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(a_arready),
    .S_AXI_RDATA(a_rdata), .S_AXI_RRESP(a_rresp), .S_AXI_RVALID(a_rvalid), .S_AXI_RREADY(rready),
    .WRADDR(a_wraddr), .BYTEEN(a_byteen), .WREN(a_wren), .WDATA(a_wdata),
    .RDADDR(a_rdaddr), .RDEN(a_rden), .RDATA(a_rdata_in)
  );

  disp_regbus_bridge #(.AXI_AWIDTH(32), .RD_LATENCY(3)) dut_b (
    .ACLK(clk), .ARST_X(arst_x),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(b_awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(b_wready),
    .S_AXI_BRESP(b_bresp), .S_AXI_BVALID(b_bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(b_arready),
    .S_AXI_RDATA(b_rdata), .S_AXI_RRESP(b_rresp), .S_AXI_RVALID(b_rvalid), .S_AXI_RREADY(rready),
    .WRADDR(b_wraddr), .BYTEEN(b_byteen), .WREN(b_wren), .WDATA(b_wdata),
    .RDADDR(b_rdaddr), .RDEN(b_rden), .RDATA(b_rdata_in)
  );

  // Register-bus read model contents.
  function automatic logic [31:0] mem(input logic [15:0] a);
    return (a == 16'h0008) ? 32'hDEADBEEF : {a, ~a};
  endfunction

  logic [2:0]  a_vpipe, b_vpipe;
  logic [15:0] a_apipe [3];
  logic [15:0] b_apipe [3];

  always @(posedge clk or negedge arst_x) begin
    if (!arst_x) begin
      a_vpipe <= '0;
      b_vpipe <= '0;
      for (int i = 0; i < 3; i++) begin
        a_apipe[i] <= '0;
        b_apipe[i] <= '0;
      end
    end else begin
      a_vpipe    <= {a_vpipe[1:0], a_rden};
      b_vpipe    <= {b_vpipe[1:0], b_rden};
      a_apipe[0] <= a_rdaddr;
      a_apipe[1] <= a_apipe[0];
      a_apipe[2] <= a_apipe[1];
      b_apipe[0] <= b_rdaddr;
      b_apipe[1] <= b_apipe[0];
      b_apipe[2] <= b_apipe[1];
    end
  end

  assign a_rdata_in = a_vpipe[0] ? mem(a_apipe[0]) : 32'h0BAD0BAD;
  assign b_rdata_in = b_vpipe[2] ? mem(b_apipe[2]) : 32'h0BAD0BAD;

  always @(posedge clk) begin
    if ((a_wren && a_rden) || (b_wren && b_rden)) overlap <= 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else n_pass++;
  endtask

  task automatic do_reset();
    arst_x = 1'b0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    bready = 1'b0; rready = 1'b0;
    tick();
    tick();
    arst_x = 1'b1;
    tick();
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input logic [15:0] ex_a, input logic [3:0] ex_be, input logic [31:0] ex_d);
    chk("awready_idle", 32'(a_awready), 1);
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("awready_full", 32'(a_awready), 0);
    chk("wren_early", 32'(a_wren), 0);
    tick();
    chk("wren", 32'(a_wren), 1);
    chk("wraddr", 32'(a_wraddr), 32'(ex_a));
    chk("byteen", 32'(a_byteen), 32'(ex_be));
    chk("wdata", a_wdata, ex_d);
    tick();
    chk("wren_pulse", 32'(a_wren), 0);
    chk("bvalid", 32'(a_bvalid), 1);
    chk("bresp", 32'(a_bresp), 0);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("bvalid_done", 32'(a_bvalid), 0);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [15:0] ex_a, input logic [31:0] ex_d);
    chk("arready_idle", 32'(a_arready), 1);
    araddr = addr;
    arvalid = 1'b1;
    tick();                                  // AR accepted at edge N
    arvalid = 1'b0;
    chk("arready_full", 32'(a_arready), 0);
    tick();                                  // cycle N+2: RDEN
    chk("rden_a", 32'(a_rden), 1);
    chk("rden_b", 32'(b_rden), 1);
    chk("rdaddr", 32'(a_rdaddr), 32'(ex_a));
    for (int k = 2; k <= 5; k++) begin
      tick();
      chk("rvalid_lat1", 32'(a_rvalid), (k >= 3) ? 1 : 0);
      chk("rvalid_lat3", 32'(b_rvalid), (k >= 5) ? 1 : 0);
    end
    chk("rdata_lat1", a_rdata, ex_d);
    chk("rdata_lat3", b_rdata, ex_d);
    chk("rresp", 32'({a_rresp, b_rresp}), 0);
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk("rvalid_done", 32'({a_rvalid, b_rvalid}), 0);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [15:0] ex_addr;
    logic [3:0]  ex_be;
    logic [31:0] ex_data;
  } wr_vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [15:0] ex_addr;
    logic [31:0] ex_data;
  } rd_vec_t;

  wr_vec_t wv [3];
  rd_vec_t rv [3];

  initial begin
    wv[0] = '{32'h0000_0004, 32'h0000_0001, 4'hF, 16'h0004, 4'hF, 32'h0000_0001};
    wv[1] = '{32'hFFFF_0010, 32'hCAFE_F00D, 4'h5, 16'h0010, 4'h5, 32'hCAFE_F00D};
    wv[2] = '{32'h1234_ABCC, 32'h8765_4321, 4'h8, 16'hABCC, 4'h8, 32'h8765_4321};
    rv[0] = '{32'h0000_0008, 16'h0008, 32'hDEAD_BEEF};
    rv[1] = '{32'hABCD_1234, 16'h1234, 32'h1234_EDCB};
    rv[2] = '{32'h0001_00F0, 16'h00F0, 32'h00F0_FF0F};

    // Reset state
    tick();
    tick();
    chk("rst_outs_a", 32'(|{a_awready, a_wready, a_bvalid, a_arready, a_rvalid, a_wren, a_rden,
                            a_bresp, a_rresp, a_rdata, a_wdata, a_wraddr, a_rdaddr, a_byteen}), 0);
    chk("rst_outs_b", 32'(|{b_awready, b_wready, b_bvalid, b_arready, b_rvalid, b_wren, b_rden,
                            b_bresp, b_rresp, b_rdata, b_wdata, b_wraddr, b_rdaddr, b_byteen}), 0);
    arst_x = 1'b1;
    tick();
    chk("ready_after_rst", 32'({a_awready, a_wready, a_arready}), 7);

    for (int i = 0; i < 3; i++)
      do_write(wv[i].addr, wv[i].data, wv[i].strb, wv[i].ex_addr, wv[i].ex_be, wv[i].ex_data);
    for (int i = 0; i < 3; i++)
      do_read(rv[i].addr, rv[i].ex_addr, rv[i].ex_data);

    // AW first, W three cycles later
    awaddr = 32'h0000_0040; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("aw_only_awready", 32'(a_awready), 0);
    chk("aw_only_wready", 32'(a_wready), 1);
    tick();
    chk("aw_only_nowren1", 32'(a_wren), 0);
    tick();
    chk("aw_only_nowren2", 32'(a_wren), 0);
    wdata = 32'h0000_00A5; wstrb = 4'h1; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    chk("w_late_nowren", 32'(a_wren), 0);
    chk("w_late_awready", 32'(a_awready), 0);
    tick();
    chk("w_late_wren", 32'(a_wren), 1);
    chk("w_late_byteen", 32'(a_byteen), 32'h1);
    chk("w_late_wraddr", 32'(a_wraddr), 32'h0040);
    chk("w_late_awready_free", 32'(a_awready), 1);
    tick();
    chk("w_late_bvalid", 32'(a_bvalid), 1);
    bready = 1'b1;
    tick();
    bready = 1'b0;

    // BREADY stall with a second write buffered
    awaddr = 32'h0000_0020; wdata = 32'h0000_0011; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    chk("stall_wren1", 32'(a_wren), 1);
    tick();
    awaddr = 32'h0000_0024; wdata = 32'h0000_0022; wstrb = 4'h3;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      chk("stall_bvalid", 32'(a_bvalid), 1);
      chk("stall_nowren", 32'(a_wren), 0);
      tick();
    end
    chk("stall_bvalid_end", 32'(a_bvalid), 1);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("stall_released", 32'({a_bvalid, a_wren}), 0);
    tick();
    chk("stall_wren2", 32'(a_wren), 1);
    chk("stall_wraddr2", 32'(a_wraddr), 32'h0024);
    chk("stall_byteen2", 32'(a_byteen), 32'h3);
    chk("stall_wdata2", a_wdata, 32'h0000_0022);
    tick();
    bready = 1'b1;
    tick();
    bready = 1'b0;

    // Arbitration: write first after reset, then read wins over a refilled write
    do_reset();
    awaddr = 32'h0000_0030; wdata = 32'h0000_0033; wstrb = 4'hF;
    araddr = 32'h0000_0008;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    tick();
    chk("arb1_wren", 32'(a_wren), 1);
    chk("arb1_rden", 32'(a_rden), 0);
    chk("arb1_wraddr", 32'(a_wraddr), 32'h0030);
    tick();
    chk("arb1_bvalid", 32'(a_bvalid), 1);
    awaddr = 32'h0000_0034; wdata = 32'h0000_0044;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("arb_idle", 32'({a_bvalid, a_wren, a_rden}), 0);
    tick();
    chk("arb2_rden", 32'(a_rden), 1);
    chk("arb2_wren", 32'(a_wren), 0);
    chk("arb2_rdaddr", 32'(a_rdaddr), 32'h0008);
    tick();
    tick();
    chk("arb2_rvalid", 32'(a_rvalid), 1);
    chk("arb2_rdata", a_rdata, 32'hDEAD_BEEF);
    rready = 1'b1;
    tick();
    chk("arb3_nowren", 32'(a_wren), 0);
    tick();
    chk("arb3_wren", 32'(a_wren), 1);
    chk("arb3_wraddr", 32'(a_wraddr), 32'h0034);
    tick();
    bready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    bready = 1'b0; rready = 1'b0;

    // Reset asserted while the read waits in RW, with new requests buffered
    do_reset();
    araddr = 32'h0000_0008; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    tick();
    chk("rst_rw_rden", 32'(a_rden), 1);
    araddr = 32'h0000_000C; awaddr = 32'h0000_0050;
    arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    arst_x = 1'b0;
    #1;
    chk("rst_rw_outs_a", 32'({a_rvalid, a_rden, a_wren, a_bvalid, a_awready, a_arready}), 0);
    chk("rst_rw_outs_b", 32'({b_rvalid, b_rden, b_wren, b_bvalid}), 0);
    tick();
    arst_x = 1'b1;
    rready = 1'b1; bready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("post_rst_quiet", 32'({a_rvalid, a_rden, a_wren, a_bvalid,
                                 b_rvalid, b_rden, b_wren, b_bvalid}), 0);
    end
    rready = 1'b0; bready = 1'b0;

    chk("wren_rden_exclusive", 32'(overlap), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
